// File: rtl/mdu_if.sv
// mdu_if: bundles the mdu_hilo request/response signals.
// master drives start/op/A/B/mthi/mtlo/flush/rhl_sel/rd_req and observes the results.
// slave is the unit side: RHLOut/MULOut/busy/done/stall are its outputs.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic        rhl_sel;
  logic        rd_req;
  logic [31:0] RHLOut;
  logic [31:0] MULOut;
  logic        busy;
  logic        done;
  logic        stall;
  modport master(output start, op, A, B, mthi, mtlo, flush, rhl_sel, rd_req,
                 input RHLOut, MULOut, busy, done, stall);
  modport slave(input start, op, A, B, mthi, mtlo, flush, rhl_sel, rd_req,
                output RHLOut, MULOut, busy, done, stall);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: EX-stage multiply/divide unit holding the HI/LO registers.
// clk, rst_n (async, active low); bus (mdu_if.slave): start/op/A/B request,
// mthi/mtlo writes, flush cancel, rhl_sel/RHLOut read port, MULOut, busy/done/stall.
module mdu_hilo #(
  parameter int MUL_LAT = 2
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);
  localparam int DIV_LAT = 33;
  typedef enum logic [1:0] {IDLE, MULS, DIVS} state_t;
  state_t      state, nxt;
  logic [5:0]  cnt;
  logic [31:0] hi, lo, mul_out, a_r, b_r, q, r, mb, r_nx;
  logic [2:0]  op_r;
  logic        done_r, accept, fin, busy, ge, neg_q, neg_r;
  logic [32:0] rs;
  logic [63:0] prod;
  assign busy       = state != IDLE;
  assign bus.busy   = busy;
  assign bus.done   = done_r;
  assign bus.MULOut = mul_out;
  assign bus.RHLOut = bus.rhl_sel ? hi : lo;
  assign bus.stall  = busy & (bus.start | bus.mthi | bus.mtlo | bus.rd_req);
  always_comb begin
    accept = !busy && bus.start && bus.op <= 3'd4 && !bus.flush;
    fin    = busy && !bus.flush && cnt == 6'd0;
    nxt    = accept ? (bus.op[1] ? DIVS : MULS) :
             (busy && (bus.flush || cnt == 6'd0)) ? IDLE : state;
  end
  // one restoring step: shift next dividend bit into the partial remainder
  always_comb begin
    rs    = {r, q[31]};
    ge    = rs >= {1'b0, mb};
    r_nx  = ge ? 32'(rs - {1'b0, mb}) : rs[31:0];
    prod  = op_r[0] ? {32'd0, a_r} * {32'd0, b_r}
                    : 64'($signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r}));
    neg_q = op_r == 3'd2 && (a_r[31] ^ b_r[31]);
    neg_r = op_r == 3'd2 && a_r[31];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      mul_out <= '0;
      done_r  <= 1'b0;
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      q       <= '0;
      r       <= '0;
      mb      <= '0;
    end else begin
      done_r <= fin;
      if (accept) begin
        a_r  <= bus.A;
        b_r  <= bus.B;
        op_r <= bus.op;
        cnt  <= bus.op[1] ? 6'(DIV_LAT - 1) : 6'(MUL_LAT - 1);
        q    <= (bus.op == 3'd2 && bus.A[31]) ? -bus.A : bus.A;
        mb   <= (bus.op == 3'd2 && bus.B[31]) ? -bus.B : bus.B;
        r    <= '0;
      end else if (busy && cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
        if (state == DIVS) begin
          q <= {q[30:0], ge};
          r <= r_nx;
        end
      end
      if (fin) begin
        if (op_r == 3'd4) mul_out <= prod[31:0];
        else if (!op_r[1]) begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end else if (b_r == '0) begin
          hi <= a_r;
          lo <= '1;
        end else begin
          hi <= neg_r ? -r : r;
          lo <= neg_q ? -q : q;
        end
      end else if (!busy && !accept) begin
        if (bus.mthi) hi <= bus.A;
        if (bus.mtlo) lo <= bus.A;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized + directed bench for mdu_hilo against an arithmetic reference model.
module tb_mdu_hilo;
  localparam int MUL_LAT = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  mdu_if bus();
  mdu_hilo #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] m_hi, m_lo, m_mul;
  logic        m_busy, m_done;
  int          m_left;
  logic [2:0]  m_op;
  logic [63:0] m_res;

  // returns {hi, lo}; for MUL only the low word matters
  function automatic logic [63:0] calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == 3'd0 || op == 3'd4) return 64'(longint'(sa) * longint'(sb));
    if (op == 3'd1) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    if (op == 3'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_mul <= '0; m_busy <= 1'b0; m_done <= 1'b0;
      m_left <= 0; m_op <= '0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (m_op == 3'd4) m_mul <= m_res[31:0];
          else begin m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; end
        end else m_left <= m_left - 1;
      end else if (bus.start && bus.op <= 3'd4 && !bus.flush) begin
        m_busy <= 1'b1;
        m_left <= (bus.op == 3'd2 || bus.op == 3'd3) ? 33 : MUL_LAT;
        m_op   <= bus.op;
        m_res  <= calc(bus.op, bus.A, bus.B);
      end else begin
        if (bus.mthi) m_hi <= bus.A;
        if (bus.mtlo) m_lo <= bus.A;
      end
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("rhlout", bus.RHLOut, bus.rhl_sel ? m_hi : m_lo);
      chk("mulout", bus.MULOut, m_mul);
      chk("stall", 32'(bus.stall), 32'(m_busy & (bus.start | bus.mthi | bus.mtlo | bus.rd_req)));
    end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.flush = 1'b0; bus.rd_req = 1'b0;
  endtask

  task automatic hl(output logic [31:0] h, output logic [31:0] l);
    bus.rhl_sel = 1'b1; #1 h = bus.RHLOut;
    bus.rhl_sel = 1'b0; #1 l = bus.RHLOut;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 60) begin cyc(); lat++; end
  endtask

  task automatic run(logic [2:0] op, logic [31:0] a, logic [31:0] b, output int lat);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    cyc();
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    wait_done(lat);
  endtask

  function automatic logic [31:0] pick();
    int k = $urandom_range(0, 9);
    return k == 0 ? 32'd0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF : 32'($urandom);
  endfunction

  logic [31:0] h, l;
  int lat;

  initial begin
    quiet(); bus.op = '0; bus.A = '0; bus.B = '0; bus.rhl_sel = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    // async reset in the middle of a divide
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.A = 32'h11; cyc(); quiet();
    run(3'd4, 32'd3, 32'd4, lat);
    chk("mul_pre", bus.MULOut, 32'hC);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7; cyc(); quiet();
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mul", bus.MULOut, 32'd0);
    hl(h, l);
    chk("rst_hi", h, 32'd0);
    chk("rst_lo", l, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (40) cyc();
    // multiplies
    run(3'd0, 32'hFFFF_FFFE, 32'd3, lat);
    chk("mult_lat", 32'(lat), 32'd2);
    hl(h, l); chk("mult_hi", h, 32'hFFFF_FFFF); chk("mult_lo", l, 32'hFFFF_FFFA);
    run(3'd1, 32'hFFFF_FFFE, 32'd3, lat);
    hl(h, l); chk("multu_hi", h, 32'h2); chk("multu_lo", l, 32'hFFFF_FFFA);
    // divides
    run(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_lat", 32'(lat), 32'd33);
    hl(h, l); chk("div_hi", h, 32'hFFFF_FFFF); chk("div_lo", l, 32'hFFFF_FFFD);
    run(3'd3, 32'hFFFF_FFF9, 32'd2, lat);
    hl(h, l); chk("divu_hi", h, 32'h1); chk("divu_lo", l, 32'h7FFF_FFFC);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    hl(h, l); chk("ovf_hi", h, 32'h0); chk("ovf_lo", l, 32'h8000_0000);
    // flush mid-divide
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd1000; bus.B = 32'd3; cyc(); quiet();
    repeat (9) cyc();
    bus.flush = 1'b1; cyc(); quiet();
    #1 chk("flush_busy", 32'(bus.busy), 32'd0);
    hl(h, l); chk("flush_hi", h, 32'h0); chk("flush_lo", l, 32'h8000_0000);
    run(3'd1, 32'd5, 32'd5, lat);
    hl(h, l); chk("m55_hi", h, 32'd0); chk("m55_lo", l, 32'd25);
    // requests while busy
    bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd100; bus.B = 32'd7; cyc(); quiet();
    cyc();
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd9; bus.B = 32'd9;
    #1 chk("stall_start", 32'(bus.stall), 32'd1);
    cyc(); quiet();
    bus.mthi = 1'b1; bus.A = 32'hDEAD;
    #1 chk("stall_mthi", 32'(bus.stall), 32'd1);
    cyc(); quiet();
    bus.rd_req = 1'b1;
    #1 chk("stall_rd", 32'(bus.stall), 32'd1);
    hl(h, l); chk("busy_old_hi", h, 32'd0); chk("busy_old_lo", l, 32'd25);
    cyc(); quiet();
    #1 chk("no_stall", 32'(bus.stall), 32'd0);
    wait_done(lat);
    hl(h, l); chk("busy_div_hi", h, 32'd2); chk("busy_div_lo", l, 32'd14);
    // divide by zero, MUL, mtlo
    run(3'd3, 32'h1234, 32'd0, lat);
    hl(h, l); chk("dz_hi", h, 32'h1234); chk("dz_lo", l, 32'hFFFF_FFFF);
    run(3'd4, 32'd7, 32'd6, lat);
    chk("mul_out", bus.MULOut, 32'h2A);
    hl(h, l); chk("mul_hi", h, 32'h1234); chk("mul_lo", l, 32'hFFFF_FFFF);
    bus.mtlo = 1'b1; bus.A = 32'h55; cyc(); quiet();
    hl(h, l); chk("mtlo_hi", h, 32'h1234); chk("mtlo_lo", l, 32'h55);
    // start dropped by flush, invalid op
    bus.start = 1'b1; bus.op = 3'd0; bus.flush = 1'b1; cyc(); quiet();
    #1 chk("flush_start", 32'(bus.busy), 32'd0);
    bus.start = 1'b1; bus.op = 3'd6; cyc(); quiet();
    #1 chk("bad_op", 32'(bus.busy), 32'd0);
    // random traffic
    repeat (2000) begin
      bus.start   = $urandom_range(0, 3) == 0;
      bus.op      = 3'($urandom_range(0, 7));
      bus.A       = pick();
      bus.B       = pick();
      bus.flush   = $urandom_range(0, 29) == 0;
      bus.rd_req  = 1'($urandom_range(0, 1));
      bus.rhl_sel = 1'($urandom_range(0, 1));
      bus.mthi    = !bus.start && $urandom_range(0, 5) == 0;
      bus.mtlo    = !bus.start && $urandom_range(0, 5) == 0;
      cyc();
    end
    quiet();
    repeat (40) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
